bucket_reduce_ctrl: RTL and testbench
=====================================

Name: bucket_reduce_ctrl

Overview:
- Downstream stage of the MSM bucket-accumulation top; starts when accumulation signals msm_done.
- Reads buckets NB-1 down to 1 and computes the running-sum reduction: S += B_j; T += S. Final T = sum of j*B_j.
- Time-shares the fixed-latency padd array: issues operand pairs and captures the sum a fixed number of cycles later.
- Tracks point-at-infinity for S, T and empty buckets, so padd is only issued when both operands are finite.

Parameters:
- WIDTH_ID, 2, bucket index width; NB = 2**WIDTH_ID buckets; bucket 0 is never read.
- WIDTH_DATA, 384, field-element width; word W = WIDTH_ID+3*WIDTH_DATA.
- PADD_LATENCY, 21, cycles from padd_in_vld to result valid on padd_result.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse (msm_done); ignored while busy=1
- bucket_flag  in  NB  bit j=1: bucket j non-empty
- r_en_bucket  out  1  bucket read strobe
- r_addr_bucket  out  WIDTH_ID  bucket read address
- data_from_bucket  in  W  read data, valid the cycle after r_en_bucket
- padd_a  out  W  padd operand a (id field driven 0)
- padd_b  out  W  padd operand b (id field driven 0)
- padd_in_vld  out  1  operand-issue strobe, one cycle
- padd_result  in  W  padd output, sampled exactly PADD_LATENCY cycles after issue
- result  out  3*WIDTH_DATA  final T as {X,Y,Z}, X in MSBs
- result_inf  out  1  result is the point at infinity
- result_vld  out  1  result/result_inf valid, held until next accepted start
- busy  out  1  reduction in progress
- done  out  1  one-cycle pulse when result becomes valid

Behaviour:
- Reset: every output 0; S, T, s_inf=1, t_inf=1 cleared; FSM in IDLE. Reset mid-operation aborts; no done pulse.
- Word layout: id in W-1 -: WIDTH_ID; coordinates in lower 3*WIDTH_DATA.
- IDLE, start=1:
  - j=NB-1; s_inf=t_inf=1; busy=1; result_vld=0; go to CHK.
- CHK:
  - bucket_flag[j]=0: S unchanged; go to T_STEP.
  - bucket_flag[j]=1: r_en_bucket=1, r_addr_bucket=j; go to RDW.
- RDW: capture data_from_bucket into B.
  - s_inf=1: S=B, s_inf=0, no padd; go to T_STEP.
  - s_inf=0: issue padd_a=S, padd_b=B; go to WAIT_S.
- WAIT_S:
  - Counter loads PADD_LATENCY-1 at issue and decrements.
  - At 0: S=padd_result coordinates; go to T_STEP.
- T_STEP:
  - s_inf=1: T unchanged; go to NEXT.
  - s_inf=0, t_inf=1: T=S, t_inf=0; go to NEXT.
  - else: issue padd_a=T, padd_b=S; go to WAIT_T.
- WAIT_T: same counting as WAIT_S; at 0 T=padd_result; go to NEXT.
- NEXT:
  - j==1: go to FIN.
  - else j=j-1; go to CHK.
- FIN:
  - result=T coordinates (0 if t_inf), result_inf=t_inf, result_vld=1, done=1, busy=0; go to IDLE.
- Timing:
  - Non-empty bucket with both adds: read at cycle c; S issue c+1; S capture c+1+L; T issue c+2+L; T capture c+2+2L (L=PADD_LATENCY).
  - Never more than one padd operation outstanding.
- bucket_flag is sampled live in CHK; the caller holds it stable while busy.
- start during busy ignored. start in the FIN cycle ignored. start the cycle after done is accepted.

Decomposition:
- msm_pkg holds:
  - W and NB localparam functions;
  - the FSM state encoding (IDLE, CHK, RDW, WAIT_S, T_STEP, WAIT_T, NEXT, FIN);
  - coordinate slice helpers.
- No sub-module: latency counter and S/T registers stay inline.

Test Plan:
- Bench uses a PADD_LATENCY-cycle delay model that adds X fields as integers.
- Full buckets: B3=3, B2=5, B1=7 -> result X=26, result_inf=0; exactly 4 padd_in_vld pulses; done exactly once.
- Bucket 2 empty: B3=3, B1=7 -> X=16; 3 padd pulses; no read of address 2.
- Single bucket: only B1=7 -> X=7; 0 padd pulses; S and T both filled by copy.
- All empty: bucket_flag=0 -> result_inf=1, result=0, no reads, done within 2*(NB-1)+3 cycles.
- start pulse while busy -> ignored, final X unchanged. Then rst_n low mid-WAIT_S -> all outputs 0, no done. After release, a new start yields the correct result.
- Latency check: PADD_LATENCY=1 and 21 both give X=26 for the full-bucket case; bench asserts padd_result is sampled exactly L cycles after each issue.

Source files
------------

// File: rtl/msm_pkg.sv
// Shared definitions for the MSM bucket pipeline.
// Holds the derived size helpers (bucket count and word width), the
// reduction FSM state encoding, and the bit positions of the id and
// coordinate fields inside a bucket word.
// A bucket word is laid out as {id, X, Y, Z}. X occupies the MSBs of the
// coordinate field.
package msm_pkg;

    // Number of buckets addressed by a WIDTH_ID-bit index.
    function automatic int calc_nb(input int width_id);
        return 32'sd1 << width_id;
    endfunction

    // Full bucket word width: id field followed by three coordinates.
    function automatic int calc_w(input int width_id, input int width_data);
        return width_id + 32'sd3 * width_data;
    endfunction

    // Width of the {X,Y,Z} coordinate field.
    function automatic int coord_w(input int width_data);
        return 32'sd3 * width_data;
    endfunction

    // LSB position of the id field; the id sits directly above the coordinates.
    function automatic int id_lsb(input int width_data);
        return 32'sd3 * width_data;
    endfunction

    // MSB position of the X coordinate inside a word.
    function automatic int x_msb(input int width_data);
        return 32'sd3 * width_data - 32'sd1;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHK    = 3'd1,
        ST_RDW    = 3'd2,
        ST_WAIT_S = 3'd3,
        ST_T_STEP = 3'd4,
        ST_WAIT_T = 3'd5,
        ST_NEXT   = 3'd6,
        ST_FIN    = 3'd7
    } state_e;

endpackage

// File: rtl/bucket_reduce_ctrl.sv
// Running-sum reduction of the MSM buckets.
// The block walks the buckets from NB-1 down to 1 and keeps two sums:
//   S += B_j and then T += S.
// When the walk is done, T = sum over j of j*B_j.
// S and T each carry a point-at-infinity flag. An empty bucket, or an
// infinite operand, never reaches the padd array: the finite operand is
// copied instead. Only one padd operation is ever in flight.
//
// Ports:
//   clk, rst_n         clock; asynchronous active-low reset
//   start              one-cycle start pulse; ignored unless IDLE
//   bucket_flag[NB]    bit j set when bucket j holds a point
//   r_en_bucket        bucket read strobe
//   r_addr_bucket      bucket read address
//   data_from_bucket   read data, valid the cycle after r_en_bucket
//   padd_a, padd_b     padd operands (id field 0)
//   padd_in_vld        padd issue strobe
//   padd_result        padd sum, valid PADD_LATENCY cycles after issue
//   result             final T as {X,Y,Z}; 0 when T is infinite
//   result_inf         final T is the point at infinity
//   result_vld         result valid until the next accepted start
//   busy               reduction in progress
//   done               one-cycle pulse when result becomes valid
module bucket_reduce_ctrl
    import msm_pkg::*;
#(
    parameter int WIDTH_ID     = 2,
    parameter int WIDTH_DATA   = 384,
    parameter int PADD_LATENCY = 21,
    localparam int NB = calc_nb(WIDTH_ID),
    localparam int W  = calc_w(WIDTH_ID, WIDTH_DATA),
    localparam int CW = coord_w(WIDTH_DATA)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [NB-1:0]       bucket_flag,
    output logic                r_en_bucket,
    output logic [WIDTH_ID-1:0] r_addr_bucket,
    input  logic [W-1:0]        data_from_bucket,
    output logic [W-1:0]        padd_a,
    output logic [W-1:0]        padd_b,
    output logic                padd_in_vld,
    input  logic [W-1:0]        padd_result,
    output logic [CW-1:0]       result,
    output logic                result_inf,
    output logic                result_vld,
    output logic                busy,
    output logic                done
);

    localparam int CNT_W = (PADD_LATENCY > 1) ? $clog2(PADD_LATENCY) : 1;
    localparam int ID_LSB = id_lsb(WIDTH_DATA);

    state_e              state_q, state_d;
    logic [WIDTH_ID-1:0] j_q, j_d;
    logic [CW-1:0]       s_q, s_d;
    logic [CW-1:0]       t_q, t_d;
    logic                s_inf_q, s_inf_d;
    logic                t_inf_q, t_inf_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]       result_q, result_d;
    logic                result_inf_q, result_inf_d;
    logic                result_vld_q, result_vld_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [CW-1:0] bucket_coord_s;
    logic [CW-1:0] padd_coord_s;
    logic          unused_id_bits_s;

    assign bucket_coord_s = data_from_bucket[CW-1:0];
    assign padd_coord_s   = padd_result[CW-1:0];
    // The id fields of the read data and of the padd result carry no meaning here.
    assign unused_id_bits_s = ^{data_from_bucket[W-1:ID_LSB], padd_result[W-1:ID_LSB]};

    assign result     = result_q;
    assign result_inf = result_inf_q;
    assign result_vld = result_vld_q;
    assign busy       = busy_q;
    assign done       = done_q;

    // Next-state logic, plus the read and issue strobes.
    // The strobes are decoded from the current state so that each issue
    // lines up with the read data in the same cycle, and the latency
    // counter then meets padd_result exactly PADD_LATENCY cycles later.
    always_comb begin
        state_d      = state_q;
        j_d          = j_q;
        s_d          = s_q;
        t_d          = t_q;
        s_inf_d      = s_inf_q;
        t_inf_d      = t_inf_q;
        cnt_d        = cnt_q;
        result_d     = result_q;
        result_inf_d = result_inf_q;
        result_vld_d = result_vld_q;
        busy_d       = busy_q;
        done_d       = 1'b0;

        r_en_bucket   = 1'b0;
        r_addr_bucket = {WIDTH_ID{1'b0}};
        padd_a        = {W{1'b0}};
        padd_b        = {W{1'b0}};
        padd_in_vld   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    j_d          = WIDTH_ID'(NB - 1);
                    s_inf_d      = 1'b1;
                    t_inf_d      = 1'b1;
                    busy_d       = 1'b1;
                    result_vld_d = 1'b0;
                    state_d      = ST_CHK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CHK: begin
                if (bucket_flag[j_q]) begin
                    r_en_bucket   = 1'b1;
                    r_addr_bucket = j_q;
                    state_d       = ST_RDW;
                end else if (s_inf_q) begin
                    // With S still infinite, the T step would change nothing, so skip it.
                    state_d = ST_NEXT;
                end else begin
                    state_d = ST_T_STEP;
                end
            end
            ST_RDW: begin
                if (s_inf_q) begin
                    s_d     = bucket_coord_s;
                    s_inf_d = 1'b0;
                    state_d = ST_T_STEP;
                end else begin
                    padd_a      = {{WIDTH_ID{1'b0}}, s_q};
                    padd_b      = {{WIDTH_ID{1'b0}}, bucket_coord_s};
                    padd_in_vld = 1'b1;
                    cnt_d       = CNT_W'(PADD_LATENCY - 1);
                    state_d     = ST_WAIT_S;
                end
            end
            ST_WAIT_S: begin
                if (cnt_q == {CNT_W{1'b0}}) begin
                    s_d     = padd_coord_s;
                    state_d = ST_T_STEP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_T_STEP: begin
                if (s_inf_q) begin
                    state_d = ST_NEXT;
                end else if (t_inf_q) begin
                    t_d     = s_q;
                    t_inf_d = 1'b0;
                    state_d = ST_NEXT;
                end else begin
                    padd_a      = {{WIDTH_ID{1'b0}}, t_q};
                    padd_b      = {{WIDTH_ID{1'b0}}, s_q};
                    padd_in_vld = 1'b1;
                    cnt_d       = CNT_W'(PADD_LATENCY - 1);
                    state_d     = ST_WAIT_T;
                end
            end
            ST_WAIT_T: begin
                if (cnt_q == {CNT_W{1'b0}}) begin
                    t_d     = padd_coord_s;
                    state_d = ST_NEXT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_NEXT: begin
                if (j_q == WIDTH_ID'(1)) begin
                    state_d = ST_FIN;
                end else begin
                    j_d     = j_q - WIDTH_ID'(1);
                    state_d = ST_CHK;
                end
            end
            ST_FIN: begin
                result_d     = t_inf_q ? {CW{1'b0}} : t_q;
                result_inf_d = t_inf_q;
                result_vld_d = 1'b1;
                done_d       = 1'b1;
                busy_d       = 1'b0;
                state_d      = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, accumulator and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            j_q          <= {WIDTH_ID{1'b0}};
            s_q          <= {CW{1'b0}};
            t_q          <= {CW{1'b0}};
            s_inf_q      <= 1'b1;
            t_inf_q      <= 1'b1;
            cnt_q        <= {CNT_W{1'b0}};
            result_q     <= {CW{1'b0}};
            result_inf_q <= 1'b0;
            result_vld_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            j_q          <= j_d;
            s_q          <= s_d;
            t_q          <= t_d;
            s_inf_q      <= s_inf_d;
            t_inf_q      <= t_inf_d;
            cnt_q        <= cnt_d;
            result_q     <= result_d;
            result_inf_q <= result_inf_d;
            result_vld_q <= result_vld_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

endmodule

// File: tb/tb_bucket_reduce_ctrl.sv
// Testbench for bucket_reduce_ctrl.
// Two instances run side by side: instance 0 with padd latency 21 and
// instance 1 with padd latency 1. A bucket memory model and a padd model
// serve each instance. The padd model adds the X coordinates and delivers
// the sum exactly L cycles after issue; in every other cycle it drives a
// poison value.
// The stimulus pushes the expected results into per-instance queues. A
// monitor pops and compares an entry on every done pulse.
module tb_bucket_reduce_ctrl;

    localparam int WID  = 2;
    localparam int WD   = 384;
    localparam int NB   = 4;
    localparam int CW   = 3 * WD;
    localparam int W    = WID + CW;
    localparam int LAT0 = 21;
    localparam int LAT1 = 1;

    typedef logic [W-1:0] word_t;

    typedef struct {
        longint x;
        longint inf;
        longint npadd;
        longint nreads;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_v   [2];
    logic            start_v [2];
    logic [NB-1:0]   flag;
    logic            r_en_v  [2];
    logic [WID-1:0]  r_addr_v[2];
    word_t           data_v  [2];
    word_t           pa_v    [2];
    word_t           pb_v    [2];
    word_t           pres_v  [2];
    logic            pvld_v  [2];
    logic [CW-1:0]   res_v   [2];
    logic            rinf_v  [2];
    logic            rvld_v  [2];
    logic            busy_v  [2];
    logic            done_v  [2];

    exp_t exp_q0[$];
    exp_t exp_q1[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   padd_seen [2];
    int   reads_seen[2];
    bit   done_prev [2];

    for (genvar k = 0; k < 2; k++) begin : g_dut
        bucket_reduce_ctrl #(
            .WIDTH_ID    (WID),
            .WIDTH_DATA  (WD),
            .PADD_LATENCY((k == 0) ? LAT0 : LAT1)
        ) u_dut (
            .clk             (clk),
            .rst_n           (rst_v[k]),
            .start           (start_v[k]),
            .bucket_flag     (flag),
            .r_en_bucket     (r_en_v[k]),
            .r_addr_bucket   (r_addr_v[k]),
            .data_from_bucket(data_v[k]),
            .padd_a          (pa_v[k]),
            .padd_b          (pb_v[k]),
            .padd_in_vld     (pvld_v[k]),
            .padd_result     (pres_v[k]),
            .result          (res_v[k]),
            .result_inf      (rinf_v[k]),
            .result_vld      (rvld_v[k]),
            .busy            (busy_v[k]),
            .done            (done_v[k])
        );
    end

    function automatic word_t mk_word(input int id, input int x, input int y);
        logic [WD-1:0] xs;
        logic [WD-1:0] ys;
        logic [WD-1:0] zs;
        logic [WID-1:0] ids;
        xs  = WD'(x);
        ys  = WD'(y);
        zs  = WD'(1);
        ids = WID'(id);
        return {ids, xs, ys, zs};
    endfunction

    function automatic word_t poison_word();
        return mk_word(0, 999, 0);
    endfunction

    // Bucket contents: B3=3, B2=5, B1=7. Bucket 0 must never be read.
    function automatic word_t mem_word(input logic [WID-1:0] a);
        case (a)
            2'd3:    return mk_word(3, 3, 3);
            2'd2:    return mk_word(2, 5, 2);
            2'd1:    return mk_word(1, 7, 1);
            default: return mk_word(0, 100, 0);
        endcase
    endfunction

    function automatic word_t padd_sum(input word_t a, input word_t b);
        logic [WD-1:0] xa;
        logic [WD-1:0] xb;
        xa = a[CW-1 -: WD];
        xb = b[CW-1 -: WD];
        return {{WID{1'b0}}, xa + xb, {WD{1'b0}}, WD'(1)};
    endfunction

    word_t pipe_dat[2][LAT0];
    logic  pipe_vld[2][LAT0];

    // Memory read port and padd delay line for both instances.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            data_v[k]      <= r_en_v[k] ? mem_word(r_addr_v[k]) : poison_word();
            pipe_vld[k][0] <= pvld_v[k];
            pipe_dat[k][0] <= padd_sum(pa_v[k], pb_v[k]);
            for (int m = 1; m < LAT0; m++) begin
                pipe_vld[k][m] <= pipe_vld[k][m-1];
                pipe_dat[k][m] <= pipe_dat[k][m-1];
            end
        end
    end

    assign pres_v[0] = (pipe_vld[0][LAT0-1] === 1'b1) ? pipe_dat[0][LAT0-1] : poison_word();
    assign pres_v[1] = (pipe_vld[1][LAT1-1] === 1'b1) ? pipe_dat[1][LAT1-1] : poison_word();

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit padd_outstanding(input int k);
        int lat;
        bit any;
        lat = (k == 0) ? LAT0 : LAT1;
        any = 1'b0;
        for (int m = 0; m < lat; m++) begin
            if (pipe_vld[k][m] === 1'b1) any = 1'b1;
        end
        return any;
    endfunction

    task automatic check_outputs_zero(input int k);
        chk("zero_r_en",       longint'(r_en_v[k]), 0);
        chk("zero_r_addr",     longint'(r_addr_v[k]), 0);
        chk("zero_padd_a",     longint'(pa_v[k] == '0), 1);
        chk("zero_padd_b",     longint'(pb_v[k] == '0), 1);
        chk("zero_padd_vld",   longint'(pvld_v[k]), 0);
        chk("zero_result",     longint'(res_v[k] == '0), 1);
        chk("zero_result_inf", longint'(rinf_v[k]), 0);
        chk("zero_result_vld", longint'(rvld_v[k]), 0);
        chk("zero_busy",       longint'(busy_v[k]), 0);
        chk("zero_done",       longint'(done_v[k]), 0);
    endtask

    // Monitor: counts issues and reads, then checks each done against the scoreboard.
    task automatic monitor_loop();
        exp_t e;
        bit   have;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (rst_v[k] !== 1'b1) begin
                    padd_seen[k]  = 0;
                    reads_seen[k] = 0;
                    done_prev[k]  = 1'b0;
                end else begin
                    if (done_prev[k]) chk("done_one_cycle", longint'(done_v[k]), 0);
                    if (pvld_v[k] === 1'b1) begin
                        padd_seen[k]++;
                        chk("padd_a_id_zero", longint'(pa_v[k][W-1 -: WID]), 0);
                        chk("padd_b_id_zero", longint'(pb_v[k][W-1 -: WID]), 0);
                        chk("single_outstanding", longint'(padd_outstanding(k)), 0);
                    end
                    if (r_en_v[k] === 1'b1) begin
                        reads_seen[k]++;
                        chk("read_nonempty_only",
                            longint'(flag[r_addr_v[k]] && (r_addr_v[k] != 2'd0)), 1);
                    end
                    if (done_v[k] === 1'b1) begin
                        have = 1'b0;
                        if (k == 0) begin
                            if (exp_q0.size() > 0) begin e = exp_q0.pop_front(); have = 1'b1; end
                        end else begin
                            if (exp_q1.size() > 0) begin e = exp_q1.pop_front(); have = 1'b1; end
                        end
                        chk("done_expected", longint'(have), 1);
                        if (have) begin
                            chk("result_x",      longint'(res_v[k][CW-1 -: 64]) , 0);
                            chk("result_x_low",  longint'(res_v[k][CW-WD +: 64]), e.x);
                            chk("result_inf",    longint'(rinf_v[k]), e.inf);
                            chk("result_vld",    longint'(rvld_v[k]), 1);
                            chk("busy_cleared",  longint'(busy_v[k]), 0);
                            chk("padd_pulses",   longint'(padd_seen[k]), e.npadd);
                            chk("bucket_reads",  longint'(reads_seen[k]), e.nreads);
                            if (e.inf != 0) chk("result_zero_inf", longint'(res_v[k] == '0), 1);
                        end
                        padd_seen[k]  = 0;
                        reads_seen[k] = 0;
                    end
                    done_prev[k] = (done_v[k] === 1'b1);
                end
            end
        end
    endtask

    task automatic pulse_start(input int k);
        start_v[k] = 1'b1;
        @(negedge clk);
        start_v[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, input int bound, output int n);
        n = 0;
        while (done_v[k] !== 1'b1 && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (done_v[k] !== 1'b1) chk("done_timeout", longint'(done_v[k]), 1);
    endtask

    function automatic exp_t mk_exp(input longint x, input longint inf,
                                    input longint np, input longint nr);
        exp_t e;
        e.x = x; e.inf = inf; e.npadd = np; e.nreads = nr;
        return e;
    endfunction

    initial begin
        int n;
        int n_done;
        rst_v[0] = 1'b0; rst_v[1] = 1'b0;
        start_v[0] = 1'b0; start_v[1] = 1'b0;
        flag = 4'b0000;
        for (int k = 0; k < 2; k++) begin
            padd_seen[k] = 0; reads_seen[k] = 0; done_prev[k] = 1'b0;
        end
        fork
            monitor_loop();
        join_none

        repeat (3) @(negedge clk);
        check_outputs_zero(0);
        check_outputs_zero(1);
        rst_v[0] = 1'b1; rst_v[1] = 1'b1;
        @(negedge clk);

        // Full buckets on both latencies: X = 3*3 + 2*5 + 1*7 = 26.
        flag = 4'b1110;
        exp_q0.push_back(mk_exp(26, 0, 4, 3));
        exp_q1.push_back(mk_exp(26, 0, 4, 3));
        start_v[0] = 1'b1; start_v[1] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0; start_v[1] = 1'b0;
        wait_done(0, 400, n);
        @(negedge clk);
        chk("result_vld_held", longint'(rvld_v[0]), 1);

        // Bucket 2 empty: X = 3*3 + 1*7 = 16.
        flag = 4'b1010;
        exp_q0.push_back(mk_exp(16, 0, 3, 2));
        pulse_start(0);
        wait_done(0, 400, n);
        @(negedge clk);

        // Only bucket 1: X = 7 with S and T filled by copy.
        flag = 4'b0010;
        exp_q0.push_back(mk_exp(7, 0, 0, 1));
        pulse_start(0);
        wait_done(0, 400, n);
        @(negedge clk);

        // All buckets empty: infinite result, within 2*(NB-1)+3 cycles.
        flag = 4'b0000;
        exp_q0.push_back(mk_exp(0, 1, 0, 0));
        pulse_start(0);
        wait_done(0, 40, n);
        chk("empty_done_latency_ok", longint'(n <= 2 * (NB - 1) + 3), 1);
        @(negedge clk);

        // A second start while busy must be ignored.
        flag = 4'b1110;
        exp_q0.push_back(mk_exp(26, 0, 4, 3));
        pulse_start(0);
        repeat (30) @(negedge clk);
        chk("busy_mid_run", longint'(busy_v[0]), 1);
        pulse_start(0);
        wait_done(0, 400, n);
        @(negedge clk);

        // Reset during WAIT_S aborts the run silently.
        pulse_start(0);
        n = 0;
        while (pvld_v[0] !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reached_wait_s", longint'(pvld_v[0]), 1);
        repeat (5) @(negedge clk);
        rst_v[0] = 1'b0;
        #1;
        check_outputs_zero(0);
        repeat (3) @(negedge clk);
        rst_v[0] = 1'b1;
        n_done = 0;
        repeat (60) begin
            @(negedge clk);
            if (done_v[0] === 1'b1) n_done++;
        end
        chk("no_done_after_abort", longint'(n_done), 0);

        // Fresh run after the abort.
        exp_q0.push_back(mk_exp(26, 0, 4, 3));
        pulse_start(0);
        wait_done(0, 400, n);

        repeat (5) @(negedge clk);
        chk("scoreboard0_drained", longint'(exp_q0.size()), 0);
        chk("scoreboard1_drained", longint'(exp_q1.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
